seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_div_pkg.sv | 34 +++
 rtl/seq_divider.sv | 142 ++++++++++++++
 tb/tb_seq_divider.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential divider.
// FSM state encoding, handshake encodings and sign/magnitude helpers.
package seq_div_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic START_ON = 1'b1;
  localparam logic STOP_ON  = 1'b1;
  localparam logic READY_ON = 1'b1;

  // v arrives sign- or zero-extended to MAX_W bits
  function automatic logic [MAX_W:0] mag(
    input logic [MAX_W-1:0] v,
    input logic             sgn
  );
    logic [MAX_W:0] w;
    w = {sgn & v[MAX_W-1], v};
    return (sgn && v[MAX_W-1]) ? -w : w;
  endfunction

  function automatic logic [MAX_W-1:0] neg_if(
    input logic [MAX_W-1:0] v,
    input logic             en
  );
    return en ? -v : v;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring radix-2 sequential divider, signed/unsigned, one step per cycle.
// Optional SEQ_DIV_EARLY_EXIT_EN: skip CALC when |dividend| < |divisor|.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH);

  div_state_e state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;

  logic signed [WIDTH-1:0] dvd_s;
  logic signed [WIDTH-1:0] dvs_s;
  logic [MAX_W-1:0] dvd_x, dvs_x;
  logic [MAX_W:0]   dvd_m, dvs_m;
  logic [MAX_W-1:0] q_ext, r_ext;
  logic [WIDTH:0]   shl, diff, rem_n;
  logic [WIDTH-1:0] quo_n, q_fin, r_fin;
  logic             dvs_zero, early, last, accept;
  logic             unused_bits;

  assign dvd_s = dividend_i;
  assign dvs_s = divisor_i;

  always_comb begin
    dvd_x = signed_i ? MAX_W'(dvd_s)
                     : MAX_W'(dividend_i);
    dvs_x = signed_i ? MAX_W'(dvs_s)
                     : MAX_W'(divisor_i);
    dvd_m = mag(dvd_x, signed_i);
    dvs_m = mag(dvs_x, signed_i);
  end

  assign dvs_zero = (divisor_i == '0);
  assign accept   = (state == IDLE) && start_i && !annul_i;

`ifdef SEQ_DIV_EARLY_EXIT_EN
  assign early = !dvs_zero && (dvd_m < dvs_m);
`else
  assign early = 1'b0;
`endif

  // Borrow out of the trial subtract decides the quotient bit
  always_comb begin
    shl   = {rem_q, quo_q[WIDTH-1]};
    diff  = shl - {1'b0, dvs_q};
    quo_n = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    rem_n = diff[WIDTH] ? shl : diff;
    q_ext = neg_if(MAX_W'(quo_n), qneg_q);
    r_ext = neg_if(MAX_W'(rem_n[WIDTH-1:0]), rneg_q);
    q_fin = q_ext[WIDTH-1:0];
    r_fin = r_ext[WIDTH-1:0];
  end

  assign last = (cnt == CW'(WIDTH - 1));
  assign unused_bits = ^{dvd_m, dvs_m, q_ext, r_ext, rem_n[WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (accept)
          state_n = (dvs_zero || early) ? DONE : CALC;
      end
      (state == CALC): begin
        if (last) state_n = DONE;
      end
      (state == DONE): state_n = IDLE;
      default:         state_n = IDLE;
    endcase
    if (annul_i) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        rem_q  <= '0;
        quo_q  <= dvd_m[WIDTH-1:0];
        dvs_q  <= dvs_m[WIDTH-1:0];
        qneg_q <= signed_i &
                  (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
        rneg_q <= signed_i & dividend_i[WIDTH-1];
      end else if (state == CALC) begin
        cnt   <= cnt + 1'b1;
        rem_q <= rem_n[WIDTH-1:0];
        quo_q <= quo_n;
      end
      if (state_n == DONE) begin
        if (state == IDLE) begin
          quotient_o    <= dvs_zero ? '1 : '0;
          remainder_o   <= dividend_i;
          div_by_zero_o <= dvs_zero;
        end else begin
          quotient_o    <= q_fin;
          remainder_o   <= r_fin;
          div_by_zero_o <= 1'b0;
        end
      end
    end
  end

  assign busy_o  = (state != IDLE);
  assign ready_o = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32).
// Expected latencies follow SEQ_DIV_EARLY_EXIT_EN when defined.
module tb_seq_divider;

  localparam int W = 32;
`ifdef SEQ_DIV_EARLY_EXIT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         annul_i;
  logic         signed_i;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         busy_o;
  logic         ready_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_by_zero_o;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .annul_i(annul_i),
    .signed_i(signed_i),
    .dividend_i(dividend_i),
    .divisor_i(divisor_i),
    .busy_o(busy_o),
    .ready_o(ready_o),
    .quotient_o(quotient_o),
    .remainder_o(remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  // Start sampled at the edge ending cycle T; lat = first k with ready in T+k
  task automatic run_div(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output int           lat,
    output logic         bz
  );
    @(negedge clk);
    start_i = 1'b1;
    signed_i = s;
    dividend_i = a;
    divisor_i = b;
    @(posedge clk);
    lat = -1;
    bz = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (!busy_o) bz = 1'b0;
      if (ready_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy: got %b want 0", busy_o);
    end
    if (ready_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_ready: got %b want 0", ready_o);
    end
    if (quotient_o !== '0) begin
      n_bad++; $display("FAIL rst_q: got %h want 0", quotient_o);
    end
    if (remainder_o !== '0) begin
      n_bad++; $display("FAIL rst_r: got %h want 0", remainder_o);
    end
    if (div_by_zero_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_dbz: got %b want 0", div_by_zero_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat;
    logic bz;
    run_div(32'd100, 32'd7, 1'b0, lat, bz);
    n_cmp += 5;
    if (lat != 33) begin
      n_bad++; $display("FAIL u100_lat: got %0d want 33", lat);
    end
    if (bz !== 1'b1) begin
      n_bad++; $display("FAIL u100_busy: got %b want 1", bz);
    end
    if (quotient_o !== 32'd14) begin
      n_bad++; $display("FAIL u100_q: got %h want %h", quotient_o, 32'd14);
    end
    if (remainder_o !== 32'd2) begin
      n_bad++; $display("FAIL u100_r: got %h want %h", remainder_o, 32'd2);
    end
    if (div_by_zero_o !== 1'b0) begin
      n_bad++; $display("FAIL u100_dbz: got %b want 0", div_by_zero_o);
    end
    @(negedge clk);
    n_cmp += 2;
    if (ready_o !== 1'b0) begin
      n_bad++; $display("FAIL u100_pulse: got %b want 0", ready_o);
    end
    if (quotient_o !== 32'd14) begin
      n_bad++; $display("FAIL u100_hold: got %h want %h", quotient_o, 32'd14);
    end
    run_div(32'hFFFF_FFFF, 32'd2, 1'b0, lat, bz);
    n_cmp += 3;
    if (lat != 33) begin
      n_bad++; $display("FAIL ubig_lat: got %0d want 33", lat);
    end
    if (quotient_o !== 32'h7FFF_FFFF) begin
      n_bad++; $display("FAIL ubig_q: got %h want 7fffffff", quotient_o);
    end
    if (remainder_o !== 32'd1) begin
      n_bad++; $display("FAIL ubig_r: got %h want 1", remainder_o);
    end
  endtask

  task automatic test_signed;
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic [W-1:0] tq [4];
    logic [W-1:0] tr [4];
    int           tl [4];
    int lat;
    logic bz;
    ta = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7,        32'hFFFF_FFFF};
    tb = '{32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd2};
    tq = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFD, 32'd0};
    tr = '{32'hFFFF_FFFF, 32'd0,         32'd1,        32'hFFFF_FFFF};
    tl = '{33, 33, 33, EARLY_LAT};
    for (int i = 0; i < 4; i++) begin
      run_div(ta[i], tb[i], 1'b1, lat, bz);
      n_cmp += 4;
      if (lat != tl[i]) begin
        n_bad++; $display("FAIL s%0d_lat: got %0d want %0d", i, lat, tl[i]);
      end
      if (quotient_o !== tq[i]) begin
        n_bad++; $display("FAIL s%0d_q: got %h want %h", i, quotient_o, tq[i]);
      end
      if (remainder_o !== tr[i]) begin
        n_bad++; $display("FAIL s%0d_r: got %h want %h", i, remainder_o, tr[i]);
      end
      if (div_by_zero_o !== 1'b0) begin
        n_bad++; $display("FAIL s%0d_dbz: got %b want 0", i, div_by_zero_o);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic bz;
    run_div(32'hFFFF_FFFF, 32'd0, 1'b0, lat, bz);
    n_cmp += 4;
    if (lat != 1) begin
      n_bad++; $display("FAIL uz_lat: got %0d want 1", lat);
    end
    if (div_by_zero_o !== 1'b1) begin
      n_bad++; $display("FAIL uz_dbz: got %b want 1", div_by_zero_o);
    end
    if (quotient_o !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL uz_q: got %h want ffffffff", quotient_o);
    end
    if (remainder_o !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL uz_r: got %h want ffffffff", remainder_o);
    end
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, lat, bz);
    n_cmp += 4;
    if (lat != 1) begin
      n_bad++; $display("FAIL sz_lat: got %0d want 1", lat);
    end
    if (div_by_zero_o !== 1'b1) begin
      n_bad++; $display("FAIL sz_dbz: got %b want 1", div_by_zero_o);
    end
    if (quotient_o !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL sz_q: got %h want ffffffff", quotient_o);
    end
    if (remainder_o !== 32'hFFFF_FFFB) begin
      n_bad++; $display("FAIL sz_r: got %h want fffffffb", remainder_o);
    end
  endtask

  task automatic test_early_exit;
    int lat;
    logic bz;
    run_div(32'd5, 32'd9, 1'b0, lat, bz);
    n_cmp += 4;
    if (lat != EARLY_LAT) begin
      n_bad++; $display("FAIL e59_lat: got %0d want %0d", lat, EARLY_LAT);
    end
    if (quotient_o !== 32'd0) begin
      n_bad++; $display("FAIL e59_q: got %h want 0", quotient_o);
    end
    if (remainder_o !== 32'd5) begin
      n_bad++; $display("FAIL e59_r: got %h want 5", remainder_o);
    end
    if (div_by_zero_o !== 1'b0) begin
      n_bad++; $display("FAIL e59_dbz: got %b want 0", div_by_zero_o);
    end
  endtask

  task automatic test_annul;
    int lat;
    logic bz;
    int rdy;
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, lat, bz);
    @(negedge clk);
    start_i = 1'b1;
    signed_i = 1'b0;
    dividend_i = 32'd100;
    divisor_i = 32'd7;
    @(posedge clk);
    rdy = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (ready_o) rdy++;
      if (k == 5) annul_i = 1'b1;
    end
    @(negedge clk);
    n_cmp += 4;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || rdy != 0) begin
      n_bad++;
      $display("FAIL an_stop: got busy %b ready %b pulses %0d want 0 0 0",
               busy_o, ready_o, rdy);
    end
    if (quotient_o !== 32'hFFFF_FFFD) begin
      n_bad++; $display("FAIL an_q: got %h want fffffffd", quotient_o);
    end
    if (remainder_o !== 32'd1) begin
      n_bad++; $display("FAIL an_r: got %h want 1", remainder_o);
    end
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL an_start: got busy %b want 0", busy_o);
    end
    rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) rdy++;
    end
    n_cmp += 4;
    if (rdy != 0) begin
      n_bad++; $display("FAIL an_noready: got %0d pulses want 0", rdy);
    end
    run_div(32'd9, 32'd3, 1'b0, lat, bz);
    if (lat != 33) begin
      n_bad++; $display("FAIL an_93_lat: got %0d want 33", lat);
    end
    if (quotient_o !== 32'd3) begin
      n_bad++; $display("FAIL an_93_q: got %h want 3", quotient_o);
    end
    if (remainder_o !== 32'd0) begin
      n_bad++; $display("FAIL an_93_r: got %h want 0", remainder_o);
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    @(negedge clk);
    start_i = 1'b1;
    signed_i = 1'b0;
    dividend_i = 32'd100;
    divisor_i = 32'd7;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start_i = (k == 3);
      if (k == 3) begin
        signed_i = 1'b1;
        dividend_i = 32'd50;
        divisor_i = 32'd5;
      end
      if (ready_o) begin
        lat = k;
        break;
      end
    end
    n_cmp += 3;
    if (lat != 33) begin
      n_bad++; $display("FAIL ig_lat: got %0d want 33", lat);
    end
    if (quotient_o !== 32'd14) begin
      n_bad++; $display("FAIL ig_q: got %h want e", quotient_o);
    end
    if (remainder_o !== 32'd2) begin
      n_bad++; $display("FAIL ig_r: got %h want 2", remainder_o);
    end
  endtask

  task automatic test_rst_midflight;
    int rdy;
    @(negedge clk);
    start_i = 1'b1;
    signed_i = 1'b0;
    dividend_i = 32'd100;
    divisor_i = 32'd7;
    @(posedge clk);
    rdy = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (ready_o) rdy++;
      if (k == 10) rst = 1'b1;
    end
    n_cmp += 2;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || div_by_zero_o !== 1'b0) begin
      n_bad++;
      $display("FAIL mr_flags: got busy %b ready %b dbz %b want 0 0 0",
               busy_o, ready_o, div_by_zero_o);
    end
    if (quotient_o !== '0 || remainder_o !== '0) begin
      n_bad++;
      $display("FAIL mr_res: got q %h r %h want 0 0",
               quotient_o, remainder_o);
    end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) rdy++;
    end
    n_cmp++;
    if (rdy != 0) begin
      n_bad++; $display("FAIL mr_noready: got %0d pulses want 0", rdy);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic bz;
    run_div(32'd5, 32'd0, 1'b0, lat, bz);
    run_div(32'd100, 32'd7, 1'b0, lat, bz);
    n_cmp += 4;
    if (lat != 33) begin
      n_bad++; $display("FAIL bb_lat: got %0d want 33", lat);
    end
    if (div_by_zero_o !== 1'b0) begin
      n_bad++; $display("FAIL bb_dbz: got %b want 0", div_by_zero_o);
    end
    if (quotient_o !== 32'd14) begin
      n_bad++; $display("FAIL bb_q: got %h want e", quotient_o);
    end
    if (remainder_o !== 32'd2) begin
      n_bad++; $display("FAIL bb_r: got %h want 2", remainder_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_i = 1'b0;
    dividend_i = '0;
    divisor_i = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_early_exit();
    test_annul();
    test_start_ignored();
    test_rst_midflight();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
